// File: rtl/seq_det_pkg.sv
// seq_det_pkg
//   Shared helpers for the programmable serial sequence detector.
//   - len_w()      : width of a pattern-length field able to hold 0..pat_w
//   - clamp_len()  : maps a requested length onto the legal range 1..pat_w
//   - len_rst()    : length register value after reset (full width)
//   - OVL_RST      : overlap-mode register value after reset
package seq_det_pkg;

  localparam logic OVL_RST = 1'b1;

  function automatic int len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  function automatic int len_rst(input int pat_w);
    return pat_w;
  endfunction

  function automatic int clamp_len(input int len, input int pat_w);
    if (len == 0) return 1;
    if (len > pat_w) return pat_w;
    return len;
  endfunction

endpackage

// File: rtl/seq_det_window.sv
// seq_det_window
//   History shift register and fill counter for the sequence detector.
//   Ports:
//     clk      : rising-edge clock
//     reset    : asynchronous active-low reset
//     shift    : an accepted bit is present; shift x into hist LSB
//     clear    : clear hist and fill (takes priority over shift)
//     fill_clr : on a shift, restart fill at 0 instead of incrementing
//     x        : serial data bit
//     hist     : last PAT_W-1 accepted bits, newest at bit 0
//     fill     : accepted bits since the last clear, saturating at PAT_W-1
module seq_det_window #(
  parameter int PAT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     shift,
  input  logic                     clear,
  input  logic                     fill_clr,
  input  logic                     x,
  output logic [PAT_W-2:0]         hist,
  output logic [$clog2(PAT_W)-1:0] fill
);

  localparam int FW = $clog2(PAT_W);
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W - 1);

  // One extra bit wide so the shift works for PAT_W = 2 as well.
  logic [PAT_W-1:0] shifted;
  assign shifted = {hist, x};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist <= '0;
      fill <= '0;
    end else if (clear) begin
      hist <= '0;
      fill <= '0;
    end else if (shift) begin
      hist <= shifted[PAT_W-2:0];
      if (fill_clr)
        fill <= '0;
      else if (fill != FILL_MAX)
        fill <= fill + FW'(1);
    end
  end

endmodule

// File: rtl/param_seq_detector.sv
// param_seq_detector
//   Runtime-programmable Mealy serial sequence detector. Compares the
//   accepted bit stream against a loaded pattern of 1..PAT_W bits, in
//   overlapping or non-overlapping mode.
//   Optional feature macro: PARAM_SEQ_DET_MATCH_CNT_EN adds match_cnt.
//   Ports:
//     clk       : rising-edge clock
//     reset     : asynchronous active-low reset
//     x         : serial data bit
//     x_valid   : x is sampled this cycle
//     cfg_load  : capture pat_in/pat_len/overlap; clears history, drops x
//     pat_in    : pattern, first-received bit at pat_in[len-1]
//     pat_len   : pattern length (0 -> 1, >PAT_W -> PAT_W)
//     overlap   : 1 = overlapping matches, 0 = non-overlapping
//     z         : combinational match pulse in the cycle of the last bit
//     match_cnt : saturating match count, trails z by one cycle (optional)
//   Handshake: a bit is accepted when x_valid = 1 and cfg_load = 0; there
//   is no back-pressure, the detector always consumes an accepted bit.
module param_seq_detector
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       x,
  input  logic                       x_valid,
  input  logic                       cfg_load,
  input  logic [PAT_W-1:0]           pat_in,
  input  logic [len_w(PAT_W)-1:0]    pat_len,
  input  logic                       overlap,
  output logic                       z
`ifdef PARAM_SEQ_DET_MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0]           match_cnt
`endif
);

  localparam int LW = len_w(PAT_W);
  localparam int FW = $clog2(PAT_W);

  logic [PAT_W-1:0] pat_r;
  logic [LW-1:0]    len_r;
  logic             ovl_r;

  logic [PAT_W-2:0] hist;
  logic [FW-1:0]    fill;

  logic             accepted;
  logic [PAT_W-1:0] window;
  logic [PAT_W-1:0] mask;
  logic             enough;
  logic             pat_eq;

  assign accepted = x_valid & ~cfg_load;
  assign window   = {hist, x};

  // Only the low len_r positions of the window take part in the compare.
  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++)
      mask[i] = (LW'(i) < len_r);
  end

  assign pat_eq = (((window ^ pat_r) & mask) == '0);
  // fill + 1 >= len_r, written without subtracting to avoid underflow.
  assign enough = ((LW'(fill) + LW'(1)) >= len_r);

  // Gated by reset so z stays low while reset is held.
  assign z = reset & accepted & enough & pat_eq;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_r <= '0;
      len_r <= LW'(len_rst(PAT_W));
      ovl_r <= OVL_RST;
    end else if (cfg_load) begin
      pat_r <= pat_in;
      len_r <= LW'(clamp_len(int'(pat_len), PAT_W));
      ovl_r <= overlap;
    end
  end

  seq_det_window #(
    .PAT_W (PAT_W)
  ) u_window (
    .clk      (clk),
    .reset    (reset),
    .shift    (accepted),
    .clear    (cfg_load),
    .fill_clr (z & ~ovl_r),
    .x        (x),
    .hist     (hist),
    .fill     (fill)
  );

`ifdef PARAM_SEQ_DET_MATCH_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      match_cnt <= '0;
    else if (cfg_load)
      match_cnt <= '0;
    else if (z && (match_cnt != {CNT_W{1'b1}}))
      match_cnt <= match_cnt + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_param_seq_detector.sv
// tb_param_seq_detector
//   Directed scenarios followed by a randomized stream, each cycle compared
//   against a reference model that keeps the accepted-bit history as a queue.
module tb_param_seq_detector;

  localparam int PAT_W = 8;
  localparam int CNT_W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic             x;
  logic             x_valid;
  logic             cfg_load;
  logic [PAT_W-1:0] pat_in;
  logic [3:0]       pat_len;
  logic             overlap;
  logic             z;
`ifdef PARAM_SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] match_cnt;
`endif

  param_seq_detector #(
    .PAT_W (PAT_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .x         (x),
    .x_valid   (x_valid),
    .cfg_load  (cfg_load),
    .pat_in    (pat_in),
    .pat_len   (pat_len),
    .overlap   (overlap),
    .z         (z)
`ifdef PARAM_SEQ_DET_MATCH_CNT_EN
    ,
    .match_cnt (match_cnt)
`endif
  );

  // ---------------- reference model ----------------
  logic [PAT_W-1:0] m_pat;
  int               m_len;
  bit               m_ovl;
  bit               m_bits[$];   // accepted bits since last clear, oldest first
  int               m_fresh;     // bits counting toward the next match
  int               m_cnt;

  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pat   = '0;
    m_len   = PAT_W;
    m_ovl   = 1'b1;
    m_bits  = {};
    m_fresh = 0;
    m_cnt   = 0;
  endtask

  // Match if at least len bits counted and the last len bits (x newest)
  // spell the pattern, first-received bit compared to pat[len-1].
  function automatic bit model_z(input bit xi, input bit vi, input bit li);
    int n;
    if (!vi || li) return 1'b0;
    if (m_fresh + 1 < m_len) return 1'b0;
    if (xi != m_pat[0]) return 1'b0;
    n = m_bits.size();
    for (int k = 1; k < m_len; k++)
      if (m_bits[n - k] != m_pat[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge(input bit xi, input bit vi, input bit li,
                            input logic [PAT_W-1:0] pi, input int pli, input bit oi,
                            input bit zi);
    if (li) begin
      m_pat   = pi;
      m_len   = (pli == 0) ? 1 : ((pli > PAT_W) ? PAT_W : pli);
      m_ovl   = oi;
      m_bits  = {};
      m_fresh = 0;
      m_cnt   = 0;
    end else if (vi) begin
      m_bits.push_back(xi);
      if (m_bits.size() > 2 * PAT_W) void'(m_bits.pop_front());
      if (zi && !m_ovl) m_fresh = 0;
      else m_fresh++;
      if (zi && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end
  endtask

  // ---------------- driver ----------------
  // Drive at the falling edge, compare z just before the rising edge.
  task automatic cycle(input bit xi, input bit vi, input bit li,
                       input logic [PAT_W-1:0] pi, input int pli, input bit oi,
                       output bit zo);
    bit ez;
    @(negedge clk);
    x = xi; x_valid = vi; cfg_load = li;
    pat_in = pi; pat_len = 4'(pli); overlap = oi;
    #1;
    ez = model_z(xi, vi, li);
    check("z_model", 32'(z), 32'(ez));
    zo = z;
    @(posedge clk);
    model_edge(xi, vi, li, pi, pli, oi, ez);
    #1;
`ifdef PARAM_SEQ_DET_MATCH_CNT_EN
    check("match_cnt_model", 32'(match_cnt), 32'(m_cnt));
`endif
  endtask

  task automatic load(input logic [PAT_W-1:0] pi, input int pli, input bit oi);
    bit zd;
    cycle(1'b0, 1'b0, 1'b1, pi, pli, oi, zd);
  endtask

  // Stream n bits MSB-first with gap idle cycles after each; exp_mask bit i
  // marks the bit indices that must raise z.
  task automatic stream(input string tag, input logic [31:0] b, input int n,
                        input int gap, input logic [31:0] exp_mask);
    bit zo;
    logic [31:0] got;
    got = '0;
    for (int i = 0; i < n; i++) begin
      cycle(b[n-1-i], 1'b1, 1'b0, '0, 0, 1'b0, zo);
      got[i] = zo;
      for (int g = 0; g < gap; g++) begin
        cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0, '0, 0, 1'b0, zo);
        check({tag, "_gap_z"}, 32'(zo), 32'd0);
      end
    end
    check({tag, "_pulses"}, got, exp_mask);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    bit zo;
    x = 0; x_valid = 0; cfg_load = 0; pat_in = '0; pat_len = '0; overlap = 0;
    reset = 1'b0;
    model_reset();
    #2;
    x = 1'b0; x_valid = 1'b1;
    #1;
    check("z_in_reset", 32'(z), 32'd0);
    x_valid = 1'b0;
    repeat (2) @(posedge clk);
`ifdef PARAM_SEQ_DET_MATCH_CNT_EN
    check("cnt_reset", 32'(match_cnt), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b1;

    // Reset config: pattern all zeros, len 8 -> needs 8 zeros.
    stream("rst_cfg", 32'h0000, 9, 0, 32'h180);

    // Overlapping 1101
    load(8'b0000_1101, 4, 1'b1);
    stream("ovl", 32'b1101011011010110, 16, 0, 32'h0908);
`ifdef PARAM_SEQ_DET_MATCH_CNT_EN
    check("cnt_ovl", 32'(match_cnt), 32'd3);
`endif

    // Non-overlapping 1101
    load(8'b0000_1101, 4, 1'b0);
    stream("novl", 32'b1101011011010110, 16, 0, 32'h0108);
`ifdef PARAM_SEQ_DET_MATCH_CNT_EN
    check("cnt_novl", 32'(match_cnt), 32'd2);
`endif

    // 101 with x_valid gaps
    load(8'b0000_0101, 3, 1'b1);
    stream("gaps", 32'b10101, 5, 2, 32'b10100);

    // Length 0 clamps to 1
    load(8'b0000_0001, 0, 1'b1);
    stream("len0", 32'b101, 3, 0, 32'b101);

    // Length above PAT_W clamps to PAT_W
    load(8'b1010_0110, 15, 1'b1);
    stream("len_big", 32'b1010_0110_1, 9, 0, 32'h080);

    // Load collides with a valid bit
    load(8'b0000_1101, 4, 1'b1);
    stream("pre_load", 32'b110, 3, 0, 32'b000);
    cycle(1'b1, 1'b1, 1'b1, 8'b0000_1101, 4, 1'b1, zo);
    check("load_z", 32'(zo), 32'd0);
    stream("post_load", 32'b1101, 4, 0, 32'b1000);

    // Async reset mid-stream
    stream("pre_rst", 32'b110, 3, 0, 32'b000);
    @(negedge clk);
    x = 1'b1; x_valid = 1'b1; cfg_load = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("z_async_rst", 32'(z), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    check("z_rst_held", 32'(z), 32'd0);
    @(negedge clk);
    x_valid = 1'b0;
    reset = 1'b1;
    stream("after_rst", 32'b1, 1, 0, 32'b0);
    load(8'b0000_1101, 4, 1'b1);
    stream("after_rst_full", 32'b1101, 4, 0, 32'b1000);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      bit vi, li;
      int pli;
      vi  = ($urandom_range(0, 99) < 75);
      li  = ($urandom_range(0, 99) < 3);
      pli = $urandom_range(0, 5);
      cycle(1'($urandom_range(0, 1)), vi, li,
            PAT_W'($urandom_range(0, 255)), pli, 1'($urandom_range(0, 1)), zo);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
